// File: rtl/tt_sw_event_encoder.sv
// Switch conditioner for the vending machine core: synchronizes and debounces the
// four switches, queues one press per switch, and hands presses to the FSM one at a time.
module tt_sw_event_encoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] sw_raw,
  output logic [3:0] sw_stable,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ack,
  output logic [3:0] pending,
  output logic       overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES*4-1:0] sync_chain;
  logic [3:0]               sync;
  logic [3:0][CNT_W-1:0]    cnt;
  logic [3:0]               stable_q;
  logic                     xfer;
  logic [3:0]               clr;
  logic [3:0]               pend_left;
  logic [3:0]               cap;
  logic [1:0]               next_code;

  assign sync = sync_chain[SYNC_STAGES*4-1 -: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES*4-5:0], sw_raw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sw_stable <= '0;
    end else if (ena) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sync[b[1:0]] != sw_stable[b[1:0]]) begin
          if (cnt[b[1:0]] == CNT_LAST) begin
            sw_stable[b[1:0]] <= ~sw_stable[b[1:0]];
            cnt[b[1:0]]       <= '0;
          end else begin
            cnt[b[1:0]] <= cnt[b[1:0]] + 1'b1;
          end
        end else begin
          cnt[b[1:0]] <= '0;
        end
      end
    end
  end

  // The presented event is chosen from pending after this edge's accept is removed;
  // presses captured on this edge are only eligible from the next edge on.
  assign xfer      = evt_valid & evt_ack;
  assign clr       = xfer ? (4'b0001 << evt_code) : '0;
  assign pend_left = pending & ~clr;
  assign cap       = ena ? (sw_stable & ~stable_q) : '0;

  always_comb begin
    next_code = 2'd0;
    if (pend_left[3])      next_code = 2'd3;
    else if (pend_left[2]) next_code = 2'd2;
    else if (pend_left[1]) next_code = 2'd1;
    else                   next_code = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q  <= '0;
      pending   <= '0;
      overrun   <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
    end else begin
      stable_q <= sw_stable;
      pending  <= pend_left | cap;
      if (|(cap & pend_left)) begin
        overrun <= 1'b1;
      end
      if (!evt_valid || xfer) begin
        evt_valid <= |pend_left;
        if (|pend_left) begin
          evt_code <= next_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_sw_event_encoder.sv
// Bench for tt_sw_event_encoder: per-cycle comparison against a behavioural model
// plus directed scenarios with literal expectations.
module tb_tt_sw_event_encoder;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] sw_raw = 4'b0000;
  logic       evt_ack = 1'b0;
  logic [3:0] sw_stable;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [3:0] pending;
  logic       overrun;

  tt_sw_event_encoder #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .sw_raw   (sw_raw),
    .sw_stable(sw_stable),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_ack  (evt_ack),
    .pending  (pending),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int deliv[4];
  int valid_cycles = 0;

  // Behavioural model: raw samples delayed through a queue, a window of the last
  // DEB enabled samples decides flips, pending is a set, m_pres the shown event.
  logic [3:0] sq[$];
  logic [3:0] win[$];
  logic [3:0] m_stable = '0;
  logic [3:0] m_prev = '0;
  logic [3:0] m_pend = '0;
  logic       m_ovr = 1'b0;
  int         m_pres = -1;

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] s, rise, nstab, p, cap;
    logic       acc, all_diff;
    if (!rst_n) begin
      m_stable = '0;
      m_prev   = '0;
      m_pend   = '0;
      m_ovr    = 1'b0;
      m_pres   = -1;
      sq.delete();
      for (int k = 0; k < SYNC; k++) sq.push_back(4'b0000);
      win.delete();
    end else begin
      s = sq[0];
      sq.push_back(sw_raw);
      void'(sq.pop_front());
      rise   = m_stable & ~m_prev;
      m_prev = m_stable;
      nstab  = m_stable;
      if (ena) begin
        win.push_back(s);
        if (win.size() > DEB) void'(win.pop_front());
        if (win.size() == DEB) begin
          for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
              if (win[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nstab[b] = ~m_stable[b];
          end
        end
      end
      p   = m_pend;
      acc = (m_pres >= 0) && evt_ack;
      if (acc) p[m_pres] = 1'b0;
      cap = ena ? rise : 4'b0000;
      if ((cap & p) != 4'b0000) m_ovr = 1'b1;
      if (m_pres < 0 || acc) begin
        m_pres = -1;
        for (int b = 3; b >= 0; b--)
          if (p[b] && m_pres < 0) m_pres = b;
      end
      m_pend   = p | cap;
      m_stable = nstab;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) deliv[k] = 0;
    valid_cycles = 0;
  endtask

  // One clock: record any accept, then compare outputs on the falling edge.
  task automatic tick();
    logic       x;
    logic [1:0] c;
    x = rst_n && evt_valid && evt_ack;
    c = evt_code;
    @(posedge clk);
    if (x) deliv[c]++;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst sw_stable", 32'(sw_stable), 32'd0);
      chk("rst pending", 32'(pending), 32'd0);
      chk("rst evt_valid", 32'(evt_valid), 32'd0);
      chk("rst evt_code", 32'(evt_code), 32'd0);
      chk("rst overrun", 32'(overrun), 32'd0);
    end else begin
      if (evt_valid) valid_cycles++;
      chk("model sw_stable", 32'(sw_stable), 32'(m_stable));
      chk("model pending", 32'(pending), 32'(m_pend));
      chk("model overrun", 32'(overrun), 32'(m_ovr));
      chk("model evt_valid", 32'(evt_valid), 32'(m_pres >= 0));
      if (m_pres >= 0) chk("model evt_code", 32'(evt_code), 32'(m_pres));
    end
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    while (!evt_valid && n < maxc) begin
      tick();
      n++;
    end
    if (!evt_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: evt_valid still 0 after %0d cycles, required 1", maxc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_counts();
    // Reset with all switches held
    sw_raw = 4'b1111;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t1 stable edge5", 32'(sw_stable), 32'h0);
    tick();
    chk("t1 stable edge6", 32'(sw_stable), 32'hf);
    tick();
    chk("t1 pending edge7", 32'(pending), 32'hf);
    chk("t1 valid edge7", 32'(evt_valid), 32'd0);
    tick();
    chk("t1 valid edge8", 32'(evt_valid), 32'd1);
    chk("t1 code edge8", 32'(evt_code), 32'd3);
    evt_ack = 1'b1;
    sw_raw  = 4'b0000;
    repeat (12) tick();
    chk("t1 delivered", 32'(deliv[0] + deliv[1] + deliv[2] + deliv[3]), 32'd4);
    chk("t1 pending drained", 32'(pending), 32'h0);
    chk("t1 overrun", 32'(overrun), 32'd0);

    // Clean press of N with ack tied high
    clear_counts();
    sw_raw = 4'b0010;
    repeat (10) tick();
    sw_raw = 4'b0000;
    repeat (10) tick();
    chk("t2 valid cycles", 32'(valid_cycles), 32'd1);
    chk("t2 N delivered", 32'(deliv[1]), 32'd1);
    chk("t2 pending", 32'(pending), 32'h0);
    chk("t2 overrun", 32'(overrun), 32'd0);

    // 3-cycle glitch on D
    clear_counts();
    sw_raw = 4'b0001;
    repeat (3) tick();
    sw_raw = 4'b0000;
    repeat (10) tick();
    chk("t3 valid cycles", 32'(valid_cycles), 32'd0);
    chk("t3 stable", 32'(sw_stable), 32'h0);

    // P and D together, ack held low for 5 presented cycles
    clear_counts();
    evt_ack = 1'b0;
    sw_raw  = 4'b1001;
    wait_valid(20);
    chk("t4 first code", 32'(evt_code), 32'd3);
    repeat (4) begin
      tick();
      chk("t4 held valid", 32'(evt_valid), 32'd1);
      chk("t4 held code", 32'(evt_code), 32'd3);
    end
    evt_ack = 1'b1;
    tick();
    chk("t4 b2b valid", 32'(evt_valid), 32'd1);
    chk("t4 b2b code", 32'(evt_code), 32'd0);
    tick();
    chk("t4 idle", 32'(evt_valid), 32'd0);
    sw_raw = 4'b0000;
    repeat (10) tick();
    chk("t4 P delivered", 32'(deliv[3]), 32'd1);
    chk("t4 D delivered", 32'(deliv[0]), 32'd1);

    // Second R press while the first is unacked
    clear_counts();
    evt_ack = 1'b0;
    sw_raw  = 4'b0100;
    repeat (8) tick();
    chk("t5 pending first", 32'(pending), 32'h4);
    chk("t5 valid first", 32'(evt_valid), 32'd1);
    chk("t5 no overrun yet", 32'(overrun), 32'd0);
    sw_raw = 4'b0000;
    repeat (8) tick();
    sw_raw = 4'b0100;
    repeat (8) tick();
    chk("t5 overrun", 32'(overrun), 32'd1);
    chk("t5 pending kept", 32'(pending), 32'h4);
    evt_ack = 1'b1;
    repeat (3) tick();
    chk("t5 pending cleared", 32'(pending), 32'h0);
    chk("t5 R delivered", 32'(deliv[2]), 32'd1);
    sw_raw = 4'b0000;
    repeat (10) tick();

    // ena low during a press of N, then re-enabled with N held
    clear_counts();
    ena    = 1'b0;
    sw_raw = 4'b0010;
    repeat (10) tick();
    chk("t6 stable frozen", 32'(sw_stable), 32'h0);
    chk("t6 no event", 32'(valid_cycles), 32'd0);
    ena = 1'b1;
    repeat (5) tick();
    chk("t6 valid at +5", 32'(evt_valid), 32'd0);
    chk("t6 pending at +5", 32'(pending), 32'h2);
    tick();
    chk("t6 valid at +6", 32'(evt_valid), 32'd1);
    chk("t6 code at +6", 32'(evt_code), 32'd1);
    repeat (3) tick();
    sw_raw = 4'b0000;
    repeat (10) tick();
    chk("t6 N delivered", 32'(deliv[1]), 32'd1);
    chk("t6 overrun sticky", 32'(overrun), 32'd1);

    // Reset mid-operation discards queue and overrun
    clear_counts();
    evt_ack = 1'b0;
    sw_raw  = 4'b1000;
    repeat (8) tick();
    chk("t7 queued", 32'(pending), 32'h8);
    rst_n  = 1'b0;
    sw_raw = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t7 pending", 32'(pending), 32'h0);
    chk("t7 overrun", 32'(overrun), 32'd0);
    chk("t7 valid", 32'(evt_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
